// File: rtl/obi_mem_responder_pkg.sv
// Constants, parameter bounds and grant-FSM state type for the OBI memory
// responder.
package obi_mem_responder_pkg;

    localparam logic [31:0] OOR_RDATA = 32'hBADC_AB1E;

    localparam int GNT_WAIT_MIN = 0;
    localparam int GNT_WAIT_MAX = 15;
    localparam int RESP_LAT_MIN = 1;
    localparam int RESP_LAT_MAX = 4;
    localparam int CNT_W        = 4;

    typedef enum logic {
        IDLE,
        STALL
    } resp_state_e;

    function automatic bit isPow2AtLeast2(input int value);
        return (value >= 2) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/obi_pkg.sv
// OBI request/response structs shared by every master and responder on the CGRA
// column links.
package obi_pkg;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

// File: rtl/obi_resp_delay_line.sv
// Fixed-latency shift register carrying {valid, data} from the accept edge to
// the rvalid cycle; invalid slots always carry zero data.
module obi_resp_delay_line #(
    parameter int RESP_LAT = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_valid_i,
    input  logic [31:0] load_data_i,
    output logic        valid_o,
    output logic [31:0] data_o
);

    logic [RESP_LAT-1:0] valid_q;
    logic [31:0]         data_q [RESP_LAT];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int i = 0; i < RESP_LAT; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= load_valid_i;
            data_q[0]  <= load_valid_i ? load_data_i : 32'h0;
            for (int i = 1; i < RESP_LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[RESP_LAT-1];
    assign data_o  = data_q[RESP_LAT-1];

endmodule

// File: rtl/obi_mem_responder.sv
// OBI responder terminating one CGRA column master with a byte-enabled word
// memory, a programmable grant stall and a fixed response latency.
module obi_mem_responder
    import obi_pkg::*;
    import obi_mem_responder_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          GNT_WAIT  = 0,
    parameter int          RESP_LAT  = 1
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  obi_req_t  req_i,
    output obi_resp_t resp_o
);

    localparam int AW = $clog2(DEPTH);

    if (GNT_WAIT < GNT_WAIT_MIN || GNT_WAIT > GNT_WAIT_MAX) begin : gBadGntWait
        $error("obi_mem_responder: GNT_WAIT out of range");
    end
    if (RESP_LAT < RESP_LAT_MIN || RESP_LAT > RESP_LAT_MAX) begin : gBadRespLat
        $error("obi_mem_responder: RESP_LAT out of range");
    end
    if (!isPow2AtLeast2(DEPTH)) begin : gBadDepth
        $error("obi_mem_responder: DEPTH must be a power of two >= 2");
    end
    if ((BASE_ADDR & (32'(DEPTH) * 32'd4 - 32'd1)) != 32'h0) begin : gBadBase
        $error("obi_mem_responder: BASE_ADDR must be DEPTH*4 aligned");
    end

    logic [29:0]   wordOff;
    logic          inRange;
    logic [AW-1:0] memIdx;
    logic          gnt;
    logic          accept;
    logic [31:0]   rspData;
    logic          dlValid;
    logic [31:0]   dlData;
    logic [31:0]   mem [DEPTH];

    // Addresses below the base wrap to huge offsets, so the explicit >= test is needed
    assign wordOff = 30'((req_i.addr - BASE_ADDR) >> 2);
    assign inRange = (req_i.addr >= BASE_ADDR) && ({2'b00, wordOff} < 32'(DEPTH));
    assign memIdx  = wordOff[AW-1:0];

    if (GNT_WAIT == 0) begin : gNoStall
        assign gnt = req_i.req;
    end else begin : gStall
        resp_state_e        state_q;
        logic [CNT_W-1:0]   cnt_q;

        // Every request, including one right after a grant, waits the full stall count
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (req_i.req) begin
                            state_q <= STALL;
                            cnt_q   <= CNT_W'(GNT_WAIT - 1);
                        end
                    end
                    STALL: begin
                        if (!req_i.req) begin
                            state_q <= IDLE;
                        end else if (cnt_q != '0) begin
                            cnt_q <= cnt_q - 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                endcase
            end
        end

        assign gnt = (state_q == STALL) && (cnt_q == '0) && req_i.req;
    end

    assign accept = req_i.req && gnt && !rst_i;

    always_ff @(posedge clk_i) begin
        if (accept && req_i.we && inRange) begin
            for (int k = 0; k < 4; k++) begin
                if (req_i.be[k]) begin
                    mem[memIdx][k*8 +: 8] <= req_i.wdata[k*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        rspData = 32'h0;
        if (!req_i.we) begin
            rspData = inRange ? mem[memIdx] : OOR_RDATA;
        end
    end

    obi_resp_delay_line #(
        .RESP_LAT (RESP_LAT)
    ) u_delay (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .load_valid_i (accept),
        .load_data_i  (rspData),
        .valid_o      (dlValid),
        .data_o       (dlData)
    );

    assign resp_o = '{gnt: gnt, rvalid: dlValid, rdata: dlData};

endmodule
